count_seq_checker: RTL

- Downstream monitor for the W-bit free-running counter. It samples the counter value on a strobe, checks that each sample equals the previous one plus 1 modulo 2^W, and acquires lock after LOCK_N consecutive correct steps.
- Once locked, it reports sequence errors and captures the first failing value pair. It also counts completed wrap-arounds.
- It sits between the counter and the status/debug register block.

---
 rtl/count_seq_checker_pkg.sv | 13 +
 rtl/sat_counter.sv | 31 +++
 rtl/count_seq_checker.sv | 122 ++++++++++++
 3 files changed

// File: rtl/count_seq_checker_pkg.sv
// rtl/count_seq_checker_pkg.sv - shared types and defaults for the counter sequence checker
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int W_DEF      = 3;
    localparam int LOCK_N_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear taking effect before increment
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        base    = clr ? '0 : count;
        count_d = base;
        if (inc && (base != {WIDTH{1'b1}})) begin
            count_d = base + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - monitors a free-running counter for +1 steps, locks, flags and captures errors
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int LOCK_N = LOCK_N_DEF,
    parameter int ECW    = 8,
    parameter int WCW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [W-1:0]   cnt,
    input  logic           clr_err,
    output logic           locked,
    output logic           err,
    output logic           err_sticky,
    output logic [ECW-1:0] err_cnt,
    output logic           cap_valid,
    output logic [W-1:0]   cap_exp,
    output logic [W-1:0]   cap_got,
    output logic [WCW-1:0] wraps
);

    state_t         state_q, state_d;
    logic [W-1:0]   prev, prev_d;
    logic [3:0]     run, run_d;
    logic [WCW-1:0] wraps_d;
    logic [W-1:0]   exp_val;
    logic           ok;
    logic           err_d;

    assign exp_val = W'(prev + W'(1));
    assign ok      = (cnt == exp_val);

    always_comb begin
        state_d = state_q;
        prev_d  = prev;
        run_d   = run;
        wraps_d = wraps;
        err_d   = 1'b0;
        if (en) begin
            prev_d = cnt;
            unique case (state_q)
                IDLE: begin
                    run_d   = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (!ok) begin
                        run_d = '0;
                    end else if (run + 4'd1 == 4'(LOCK_N)) begin
                        run_d   = '0;
                        state_d = LOCKED;
                    end else begin
                        run_d = run + 4'd1;
                    end
                end
                LOCKED: begin
                    if (ok) begin
                        if (prev == {W{1'b1}}) begin
                            wraps_d = wraps + WCW'(1);
                        end
                    end else begin
                        err_d   = 1'b1;
                        run_d   = '0;
                        state_d = SYNC;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev       <= '0;
            run        <= '0;
            wraps      <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            cap_valid  <= 1'b0;
            cap_exp    <= '0;
            cap_got    <= '0;
        end else begin
            state_q <= state_d;
            prev    <= prev_d;
            run     <= run_d;
            wraps   <= wraps_d;
            locked  <= (state_d == LOCKED);
            err     <= err_d;
            if (err_d) begin
                err_sticky <= 1'b1;
            end else if (clr_err) begin
                err_sticky <= 1'b0;
            end
            // A clear in the same cycle frees the capture for this error
            if (err_d && (clr_err || !cap_valid)) begin
                cap_valid <= 1'b1;
                cap_exp   <= exp_val;
                cap_got   <= cnt;
            end else if (clr_err) begin
                cap_valid <= 1'b0;
                cap_exp   <= '0;
                cap_got   <= '0;
            end
        end
    end

    sat_counter #(
        .WIDTH(ECW)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (err_d),
        .clr  (clr_err),
        .count(err_cnt)
    );

endmodule
